// File: rtl/cycle_counter.sv
// rtl/cycle_counter.sv - free-running cycle counter with halt freeze and sticky wrap flag
module cycle_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    output logic [WIDTH-1:0] count,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Counts raw clk edges; deliberately ignores the pipeline clock-enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            wrapped <= 1'b0;
        end else if (!halt) begin
            count <= count + ONE;
            if (&count) begin
                wrapped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cycle_counter.sv
// tb/tb_cycle_counter.sv - self-checking bench for cycle_counter at WIDTH=32 and WIDTH=4
module tb_cycle_counter;

    logic        clk = 1'b0;
    logic        rst32 = 1'b1;
    logic        halt32 = 1'b0;
    logic        rst4 = 1'b1;
    logic        halt4 = 1'b0;
    logic [31:0] count32;
    logic        wrapped32;
    logic [3:0]  count4;
    logic        wrapped4;

    always #5 clk = ~clk;

    cycle_counter dut32 (
        .clk     (clk),
        .rst     (rst32),
        .halt    (halt32),
        .count   (count32),
        .wrapped (wrapped32)
    );

    cycle_counter #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst4),
        .halt    (halt4),
        .count   (count4),
        .wrapped (wrapped4)
    );

    typedef struct {
        logic       rst;
        logic       halt;
        logic [3:0] exp_count;
        logic       exp_wrapped;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain modular arithmetic plus a sticky flag.
    longint unsigned m32 = 0;
    bit              w32 = 0;
    int              m4  = 0;
    bit              w4  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (rst32) begin
            m32 = 0;
            w32 = 0;
        end else if (!halt32) begin
            m32 = (m32 + 1) % 64'h1_0000_0000;
            if (m32 == 0) w32 = 1;
        end
        if (rst4) begin
            m4 = 0;
            w4 = 0;
        end else if (!halt4) begin
            m4 = (m4 + 1) % 16;
            if (m4 == 0) w4 = 1;
        end
        chk({tag, "_count32"},   count32,   m32);
        chk({tag, "_wrapped32"}, wrapped32, 64'(w32));
        chk({tag, "_count4"},    count4,    64'(m4));
        chk({tag, "_wrapped4"},  wrapped4,  64'(w4));
    endtask

    task automatic add(input logic r, input logic h, input int c, input logic w);
        vec_t v;
        v.rst = r;
        v.halt = h;
        v.exp_count = 4'(c);
        v.exp_wrapped = w;
        vecs.push_back(v);
    endtask

    initial begin
        // Table for the WIDTH=4 instance; dut32 receives the same inputs.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0);
        for (int i = 1; i <= 15; i++) add(0, 0, i, 0);
        add(0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) add(0, 0, i, 1);
        add(1, 0, 0, 0);
        add(0, 0, 1, 0);
        for (int i = 2; i <= 5; i++) add(0, 0, i, 0);
        for (int i = 0; i < 7; i++) add(0, 1, 5, 0);
        add(0, 0, 6, 0);
        add(0, 0, 7, 0);
        for (int i = 0; i < 2; i++) add(0, 0, 8 + i, 0);
        add(1, 1, 0, 0);
        add(0, 1, 0, 0);
        add(0, 1, 0, 0);
        add(0, 0, 1, 0);

        #2;
        foreach (vecs[i]) begin
            rst4   = vecs[i].rst;
            halt4  = vecs[i].halt;
            rst32  = vecs[i].rst;
            halt32 = vecs[i].halt;
            tick("table");
            chk($sformatf("vec%0d_count4", i), count4, 64'(vecs[i].exp_count));
            chk($sformatf("vec%0d_wrapped4", i), wrapped4, 64'(vecs[i].exp_wrapped));
        end

        // WIDTH=32: reset for 3 edges, then 10 counting edges.
        rst32 = 1; halt32 = 0;
        for (int i = 0; i < 3; i++) tick("rst32");
        chk("reset_count32", count32, 0);
        chk("reset_wrapped32", wrapped32, 0);
        rst32 = 0;
        for (int i = 0; i < 10; i++) tick("run32");
        chk("ten_edges_count32", count32, 10);

        // halt pulses that never coincide with a posedge are invisible.
        rst4 = 0; halt4 = 0;
        for (int i = 0; i < 4; i++) begin
            #2 halt32 = 1; halt4 = 1;
            #3 halt32 = 0; halt4 = 0;
            tick("glitch");
            chk("glitch_count32", count32, 64'(11 + i));
        end

        // Randomized run against the model on both instances.
        for (int i = 0; i < 3000; i++) begin
            rst32  = ($urandom_range(0, 63) == 0);
            halt32 = ($urandom_range(0, 3) == 0);
            rst4   = ($urandom_range(0, 99) == 0);
            halt4  = ($urandom_range(0, 4) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
